// File: rtl/iob_timer_core.sv
// iob_timer_core: 64-bit prescaled up-counter with snapshot latch,
// sticky overflow flag and optional compare interrupt.
// Ports: clk, rst (sync, active high), en, rst_soft, presc, sample,
//   ovf_clr, cmp_val, irq_clr -> cnt_live, tmr_value, sample_ok, ovf, irq.
// Optional compare interrupt is built only when TIMER_CMP_EN is defined;
// otherwise irq is tied low and cmp_val/irq_clr are ignored.
module iob_timer_core #(
    parameter int COUNT_W = 64,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rst_soft,
    input  logic [PRESC_W-1:0] presc,
    input  logic               sample,
    input  logic               ovf_clr,
    input  logic [COUNT_W-1:0] cmp_val,
    input  logic               irq_clr,
    output logic [COUNT_W-1:0] cnt_live,
    output logic [COUNT_W-1:0] tmr_value,
    output logic               sample_ok,
    output logic               ovf,
    output logic               irq
);

    typedef enum logic {STOP, RUN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 tick;
    logic [COUNT_W-1:0]   cnt;
    logic [COUNT_W-1:0]   cnt_inc;
    logic [PRESC_W-1:0]   presc_cnt;
    logic                 wrap;

    assign cnt_inc  = cnt + 1'b1;
    assign wrap     = tick & (&cnt);
    assign cnt_live = cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= STOP;
        else     state <= state_nxt;
    end

    // The >= compare lets a lowered presc tick at once instead of
    // waiting for presc_cnt to wrap around.
    always_comb begin
        state_nxt = STOP;
        tick      = 1'b0;
        if (en) state_nxt = RUN;
        if (state == RUN) tick = (presc_cnt >= presc);
    end

    always_ff @(posedge clk) begin
        if (rst || rst_soft) begin
            cnt       <= '0;
            presc_cnt <= '0;
            tmr_value <= '0;
            sample_ok <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            sample_ok <= sample;
            // Capture the pre-increment value when a tick coincides.
            if (sample) tmr_value <= cnt;
            if (state == RUN) begin
                if (tick) begin
                    presc_cnt <= '0;
                    cnt       <= cnt_inc;
                end else begin
                    presc_cnt <= presc_cnt + 1'b1;
                end
            end
            ovf <= wrap | (ovf & ~ovf_clr);
        end
    end

`ifdef TIMER_CMP_EN
    logic cmp_hit;

    assign cmp_hit = tick & (cnt_inc == cmp_val);

    always_ff @(posedge clk) begin
        if (rst || rst_soft) irq <= 1'b0;
        else                 irq <= cmp_hit | (irq & ~irq_clr);
    end
`else
    logic unused_cmp;

    assign unused_cmp = ^{cmp_val, irq_clr};
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_iob_timer_core.sv
// tb_iob_timer_core: directed self-checking bench for iob_timer_core.
// A 4-bit instance shares the controls to exercise counter wrap.
module tb_iob_timer_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rst_soft;
    logic [15:0] presc;
    logic        sample;
    logic        ovf_clr;
    logic [63:0] cmp_val;
    logic        irq_clr;
    logic [63:0] cnt_live;
    logic [63:0] tmr_value;
    logic        sample_ok;
    logic        ovf;
    logic        irq;

    logic [3:0]  cmp2 = 4'd0;
    logic [3:0]  cnt2;
    logic [3:0]  tmr2;
    logic        sok2;
    logic        ovf2;
    logic        irq2;

    int n_chk  = 0;
    int n_pass = 0;
    logic prev_irq;

    always #5 clk = ~clk;

    iob_timer_core #(.COUNT_W(64), .PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .rst_soft(rst_soft),
        .presc(presc), .sample(sample), .ovf_clr(ovf_clr),
        .cmp_val(cmp_val), .irq_clr(irq_clr),
        .cnt_live(cnt_live), .tmr_value(tmr_value),
        .sample_ok(sample_ok), .ovf(ovf), .irq(irq)
    );

    iob_timer_core #(.COUNT_W(4), .PRESC_W(16)) dut_w (
        .clk(clk), .rst(rst), .en(en), .rst_soft(rst_soft),
        .presc(presc), .sample(sample), .ovf_clr(ovf_clr),
        .cmp_val(cmp2), .irq_clr(irq_clr),
        .cnt_live(cnt2), .tmr_value(tmr2),
        .sample_ok(sok2), .ovf(ovf2), .irq(irq2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rst_soft = 1'b0; presc = '0;
        sample = 1'b0; ovf_clr = 1'b0; cmp_val = '0; irq_clr = 1'b0;

        // reset held with en=1
        step(1);
        chk("rst_cnt0", cnt_live, 0);
        step(1);
        chk("rst_cnt1", cnt_live, 0);
        chk("rst_tmr", tmr_value, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_irq", irq, 0);
        chk("rst_sok", sample_ok, 0);

        // prescale by 4 for 40 enabled cycles, then stop
        rst = 1'b0; en = 1'b0; presc = 16'd3;
        step(1);
        en = 1'b1;
        step(40);
        en = 1'b0;
        step(10);
        chk("presc3_cnt", cnt_live, 10);
        step(5);
        chk("stop_hold", cnt_live, 10);

        // snapshot at 0x25
        presc = 16'd0; en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cnt_live == 64'h25) break;
            step(1);
        end
        chk("reach_25", cnt_live, 64'h25);
        sample = 1'b1;
        step(1);
        sample = 1'b0;
        chk("snap_val", tmr_value, 64'h25);
        chk("snap_ok", sample_ok, 1);
        step(3);
        chk("snap_ok_low", sample_ok, 0);
        chk("snap_frozen", tmr_value, 64'h25);
        chk("cnt_adv", cnt_live, 64'h29);
        sample = 1'b1;
        step(1);
        chk("b2b_val0", tmr_value, 64'h29);
        chk("b2b_ok0", sample_ok, 1);
        step(1);
        sample = 1'b0;
        chk("b2b_val1", tmr_value, 64'h2a);
        chk("b2b_ok1", sample_ok, 1);

        // soft clear beats sample
        for (int i = 0; i < 400; i++) begin
            if (cnt_live == 64'h100) break;
            step(1);
        end
        chk("reach_100", cnt_live, 64'h100);
        rst_soft = 1'b1; sample = 1'b1;
        step(1);
        rst_soft = 1'b0; sample = 1'b0;
        chk("soft_cnt", cnt_live, 0);
        chk("soft_tmr", tmr_value, 0);
        chk("soft_sok", sample_ok, 0);
        chk("soft_tmr_w", tmr2, 0);
        chk("soft_sok_w", sok2, 0);
        step(1);
        chk("soft_sok_nxt", sample_ok, 0);
        chk("soft_cnt_nxt", cnt_live, 1);

        // presc lowered below presc_cnt
        presc = 16'd15; rst_soft = 1'b1;
        step(1);
        rst_soft = 1'b0;
        step(10);
        chk("hi_presc", cnt_live, 0);
        presc = 16'd2;
        step(1);
        chk("lower_tick", cnt_live, 1);
        step(2);
        chk("lower_wait", cnt_live, 1);
        step(1);
        chk("lower_next", cnt_live, 2);

        // wrap on the 4-bit instance
        presc = 16'd0; rst_soft = 1'b1;
        step(1);
        rst_soft = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt2 == 4'he) break;
            step(1);
        end
        chk("reach_e", cnt2, 4'he);
        chk("ovf_pre", ovf2, 0);
        step(1);
        chk("cnt_f", cnt2, 4'hf);
        chk("ovf_f", ovf2, 0);
        step(1);
        chk("wrap_cnt", cnt2, 0);
        chk("wrap_ovf", ovf2, 1);
`ifdef TIMER_CMP_EN
        chk("wrap_irq", irq2, 1);
`else
        chk("wrap_irq", irq2, 0);
`endif
        step(2);
        chk("ovf_sticky", ovf2, 1);
        en = 1'b0;
        step(2);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf2, 0);

        // compare interrupt
        en = 1'b1; presc = 16'd1; cmp_val = 64'd5; rst_soft = 1'b1;
        step(1);
        rst_soft = 1'b0;
        prev_irq = irq;
        for (int i = 0; i < 40; i++) begin
            if (cnt_live == 64'd5) break;
            prev_irq = irq;
            step(1);
        end
        chk("reach_5", cnt_live, 5);
        chk("irq_before", prev_irq, 0);
`ifdef TIMER_CMP_EN
        chk("irq_at5", irq, 1);
        step(6);
        chk("irq_sticky", irq, 1);
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        chk("irq_clr", irq, 0);
`else
        chk("irq_at5", irq, 0);
        step(6);
        chk("irq_off", irq, 0);
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
        chk("irq_off2", irq, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
